pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Measures the spacing between enable-qualified input pulses and reports each interval as a `max`-style value (period minus one) through a valid/ready output register. It is the receive side of a wrap-on-maximum counter's pulse output: it recovers the programmed maximum from the pulse stream. It sits in the arithmetic/timing primitives alongside the counters and is used for rate checking and self-test of periodic pulse generators.

## Interface
- `WIDTH`, 32: width of the internal counter and of the reported period.
- `clk`  input  1  clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `ena`  input  1  tick enable; only cycles with `ena=1` are counted, and `pls` is sampled only on them.
- `pls`  input  1  pulse to measure; qualified pulse = `ena & pls`.
- `clr`  input  1  synchronous clear: drop the reference pulse, pending result and statistics.
- `per`  output  WIDTH  measured period minus one.
- `ovf`  output  1  `per` saturated; the interval exceeded 2^WIDTH ticks.
- `vld`  output  1  result valid.
- `rdy`  input  1  result accepted when `vld & rdy`.
- `drp`  output  1  one-cycle pulse: a completed result was discarded because the output register was full.
- `min`  output  WIDTH  smallest non-overflowed `per` since reset/`clr` (statistics only).
- `max`  output  WIDTH  largest `per` since reset/`clr`, overflow included (statistics only).

## Operation
- Two states: WAIT (no reference pulse yet) and MEAS (counting since last pulse). Reset state is WAIT.
- Transitions:
  - WAIT, qualified pulse -> MEAS, `cnt<=0`, no result.
  - MEAS, `ena & ~pls` -> `cnt<=cnt+1`, saturating at all-ones; saturation sets internal `sat`.
  - MEAS, qualified pulse -> capture `cnt` and `sat`, `cnt<=0`, `sat<=0`, stay in MEAS. Measurement is continuous: every pulse both ends one interval and starts the next.
- Pulses at qualified ticks t0 and t1 give `per = t1-t0-1`. Consecutive ticks give 0. A period of N ticks gives N-1.
- Overflow:
  - If the interval is longer than 2^WIDTH ticks, the result is `per = all-ones` with `ovf=1`.
  - An interval of exactly 2^WIDTH ticks gives all-ones with `ovf=0`.
- Output register:
  - Single entry.
  - A capture loads `per`/`ovf` and sets `vld` when the register is empty or is being accepted in the same cycle (`vld & rdy`).
  - Otherwise the new result is discarded and `drp=1` for that cycle.
  - `vld` falls after `vld & rdy` when there is no simultaneous capture.
  - `per`/`ovf` hold while `vld=1 & rdy=0`.
- `clr`:
  - Priority over everything else.
  - Next state WAIT, `cnt=0`, `sat=0`, `vld=0`, `drp=0`, statistics reset.
  - A pulse in the same cycle is ignored.
- `ena=0` freezes `cnt` and state; `pls` is ignored.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).
- Reset values: `per=0`, `ovf=0`, `vld=0`, `drp=0`, `min=all-ones`, `max=0`, state WAIT.

## Timing
- Qualified pulse in cycle N -> `vld=1`, with `per`/`ovf` valid, from cycle N+1.
- `drp` asserts in cycle N+1 for a pulse in cycle N that found the register full and not being accepted.
- `min`/`max` update in cycle N+1 together with a loaded result. Dropped results do not update them.
- Accepting in cycle N while a capture occurs in cycle N keeps `vld=1`, with the new value in N+1.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- Macro `PULSE_PERIOD_METER_MINMAX_EN`.
- Defined:
  - `min`/`max` statistics registers are implemented.
  - `min` updates only on results with `ovf=0`.
  - `max` updates on every loaded result.
- Undefined:
  - No statistics registers.
  - `min` and `max` are constant 0.
  - All other behaviour is identical.

## Test plan
- **Periodic pulses:** `WIDTH=8`, `ena=1`, `rdy=1`, pulse every 5 cycles -> first pulse gives no result; each subsequent pulse gives `per=4`, `ovf=0`, `vld` one cycle after the pulse.
- **Gated ticks and back-to-back pulses:**
  - `ena` toggling 1/0, pulse every 3rd qualified tick -> `per=2`; pulses with `ena=0` are ignored.
  - Back-to-back qualified pulses -> `per=0`.
- **Overflow boundary:** `WIDTH=4`.
  - Pulses 16 ticks apart -> `per=15`, `ovf=0`.
  - Pulses 20 ticks apart -> `per=15`, `ovf=1`.
  - Next 3-tick interval -> `per=2`, `ovf=0`.
- **Backpressure:**
  - `rdy=0`, three intervals of 2 ticks -> first result held, `drp` pulses twice, `per=1` stable.
  - `rdy=1` in the same cycle as a capture -> `vld` stays 1 with the new value.
- **Clear and reset:**
  - `clr` with a simultaneous pulse mid-MEAS -> `vld=0`, the pulse is ignored; the next pulse only re-arms, with no result.
  - `rst` asserted mid-interval -> all outputs at reset values within the same cycle.
- **Statistics (macro defined):** intervals 4, 7, 2 ticks, then an overflow -> `min=1`, `max=all-ones`. With the macro undefined, `min=max=0` throughout.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures the spacing between enable-qualified pulses and reports it as period-1 through a
// single-entry valid/ready register. Optional min/max statistics: PULSE_PERIOD_METER_MINMAX_EN.
module pulse_period_meter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pls,
  input  logic             clr,
  output logic [WIDTH-1:0] per,
  output logic             ovf,
  output logic             vld,
  input  logic             rdy,
  output logic             drp,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  // state  | meaning
  // S_WAIT | no reference pulse seen yet
  // S_MEAS | counting ticks since the last qualified pulse
  typedef enum logic {S_WAIT, S_MEAS} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             sat;
  logic             qual, capture, load, drop;

  assign qual = ena & pls;
  assign load = capture & (~vld | rdy);
  assign drop = capture & vld & ~rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (clr) begin
      state_nxt = S_WAIT;
    end else if (qual) begin
      state_nxt = S_MEAS;
      capture   = (state == S_MEAS);
    end
  end

  // Saturation keeps cnt at all-ones and flags the interval as longer than 2^WIDTH ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (qual) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (ena && state == S_MEAS) begin
      if (&cnt) sat <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per <= '0;
      ovf <= 1'b0;
      vld <= 1'b0;
      drp <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
      drp <= 1'b0;
    end else begin
      drp <= drop;
      if (load) begin
        per <= cnt;
        ovf <= sat;
        vld <= 1'b1;
      end else if (rdy) begin
        vld <= 1'b0;
      end
    end
  end

`ifdef PULSE_PERIOD_METER_MINMAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min <= '1;
      max <= '0;
    end else if (clr) begin
      min <= '1;
      max <= '0;
    end else if (load) begin
      if (!sat && cnt < min) min <= cnt;
      if (cnt > max)         max <= cnt;
    end
  end
`else
  assign min = '0;
  assign max = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: directed scenarios plus random traffic against
// a tick-index reference model (intervals computed as differences of qualified tick numbers).
module tb_pulse_period_meter;
  localparam int     W    = 4;
  localparam longint ALL1 = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, ena, pls, clr, rdy;
  logic [W-1:0] per, min, max;
  logic         ovf, vld, drp;

  int checks = 0;
  int errors = 0;

  bit     m_armed, m_vld, m_ovf, m_drp;
  longint m_tick, m_t0, m_per, m_min, m_max;

  pulse_period_meter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pls(pls), .clr(clr),
    .per(per), .ovf(ovf), .vld(vld), .rdy(rdy), .drp(drp),
    .min(min), .max(max)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_vld = 0; m_ovf = 0; m_drp = 0;
    m_tick = 0; m_t0 = 0; m_per = 0; m_min = ALL1; m_max = 0;
  endtask

  task automatic model_step(input bit e, input bit p, input bit c, input bit r);
    bit     cap;
    longint d, np;
    bit     no;
    cap = 0; np = 0; no = 0;
    if (c) begin
      m_armed = 0; m_vld = 0; m_drp = 0; m_min = ALL1; m_max = 0;
      return;
    end
    m_drp = 0;
    if (e) begin
      m_tick++;
      if (p) begin
        if (m_armed) begin
          d   = m_tick - m_t0;
          cap = 1;
          no  = (d - 1 > ALL1);
          np  = no ? ALL1 : d - 1;
        end
        m_t0 = m_tick;
        m_armed = 1;
      end
    end
    if (cap && (!m_vld || r)) begin
      m_vld = 1; m_per = np; m_ovf = no;
      if (!no && np < m_min) m_min = np;
      if (np > m_max) m_max = np;
    end else if (cap) begin
      m_drp = 1;
    end else if (m_vld && r) begin
      m_vld = 0;
    end
  endtask

  task automatic compare_all();
    check_val("vld", vld, m_vld);
    check_val("drp", drp, m_drp);
    if (m_vld) begin
      check_val("per", per, m_per);
      check_val("ovf", ovf, m_ovf);
    end
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    check_val("min", min, m_min);
    check_val("max", max, m_max);
`else
    check_val("min", min, 0);
    check_val("max", max, 0);
`endif
  endtask

  task automatic cycle(input bit e, input bit p, input bit c, input bit r);
    ena = e; pls = p; clr = c; rdy = r;
    model_step(e, p, c, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_per"}, per, 0);
    check_val({tag, "_ovf"}, ovf, 0);
    check_val({tag, "_vld"}, vld, 0);
    check_val({tag, "_drp"}, drp, 0);
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    check_val({tag, "_min"}, min, ALL1);
`else
    check_val({tag, "_min"}, min, 0);
`endif
    check_val({tag, "_max"}, max, 0);
  endtask

  initial begin
    rst = 1'b1; ena = 0; pls = 0; clr = 0; rdy = 1;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // periodic pulses, period 5
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 1);
      if (k == 0) check_val("period5_first_no_result", vld, 0);
      else        check_val("period5_per", per, 4);
      idle(4, 1);
    end

    // gated ticks: ena toggles, pulse every 3rd qualified tick, pulses while ena=0 ignored
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) cycle(1, ((k / 2) % 3) == 0, 0, 1);
      else            cycle(0, 1, 0, 1);
    end
    check_val("gated_per", per, 2);

    // back-to-back qualified pulses
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 1);
    check_val("b2b_per", per, 0);

    // overflow boundary
    cycle(0, 0, 1, 1);
    cycle(1, 1, 0, 1);
    idle(15, 1);
    cycle(1, 1, 0, 1);
    check_val("ovf16_per", per, 15);
    check_val("ovf16_ovf", ovf, 0);
    idle(19, 1);
    cycle(1, 1, 0, 1);
    check_val("ovf20_per", per, 15);
    check_val("ovf20_ovf", ovf, 1);
    idle(2, 1);
    cycle(1, 1, 0, 1);
    check_val("after_ovf_per", per, 2);
    check_val("after_ovf_ovf", ovf, 0);

    // backpressure: three 2-tick intervals with rdy=0
    cycle(0, 0, 1, 1);
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      check_val("bp_per_held", per, 1);
      if (k > 0) check_val("bp_drp", drp, 1);
    end
    cycle(1, 0, 0, 0);
    check_val("bp_drp_one_cycle", drp, 0);
    cycle(1, 1, 0, 1);
    check_val("accept_capture_vld", vld, 1);
    cycle(1, 0, 0, 1);
    check_val("accept_drains_vld", vld, 0);

    // clr with simultaneous pulse mid-MEAS, next pulse only re-arms
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    check_val("clr_vld", vld, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    check_val("rearm_no_result", vld, 0);
    idle(2, 1);
    cycle(1, 1, 0, 0);
    check_val("rearm_then_per", per, 2);

    // async reset mid-interval
    idle(3, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // statistics: intervals 4, 7, 2 then an overflow
    cycle(1, 1, 0, 1);
    idle(3, 1); cycle(1, 1, 0, 1);
    idle(6, 1); cycle(1, 1, 0, 1);
    idle(1, 1); cycle(1, 1, 0, 1);
    idle(24, 1); cycle(1, 1, 0, 1);
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    check_val("stats_min", min, 1);
    check_val("stats_max", max, ALL1);
`else
    check_val("stats_min_off", min, 0);
    check_val("stats_max_off", max, 0);
`endif

    // random traffic with varying pulse density
    for (int k = 0; k < 3000; k++) begin
      int pden;
      pden = (k / 500) % 3 == 0 ? 40 : ((k / 500) % 3 == 1 ? 8 : 3);
      cycle($urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < pden,
            $urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
